// File: rtl/xbus_pe_receiver.sv
// PE-side receiver for the X-bus G2B triplet stream: captures tag-matched triplets into a
// small FIFO, presents them to the PE over valid/ready, and tracks a kernel_size delivery window.
module xbus_pe_receiver #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int TW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clr,
   input  logic [TW-1:0]           X_ID,
   input  logic                    bus_valid,
   output logic                    bus_ready,
   input  logic [TW-1:0]           X_TAG,
   input  logic [DATA_WIDTH-1:0]   ifmap_data_G2B,
   input  logic [DATA_WIDTH-1:0]   fltr_data_G2B,
   input  logic [2*DATA_WIDTH-1:0] psum_data_G2B,
   input  logic                    start,
   input  logic [7:0]              kernel_size,
   output logic                    pe_valid,
   input  logic                    pe_ready,
   output logic [DATA_WIDTH-1:0]   pe_ifmap,
   output logic [DATA_WIDTH-1:0]   pe_fltr,
   output logic [2*DATA_WIDTH-1:0] pe_psum,
   output logic [CW-1:0]           fill_level,
   output logic                    window_busy,
   output logic                    window_done,
   output logic                    err_excess
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0]   r_mem_ifmap [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   r_mem_fltr  [FIFO_DEPTH];
   logic [2*DATA_WIDTH-1:0] r_mem_psum  [FIFO_DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_remaining;
   logic [7:0]    w_remaining_next;
   logic          r_done;
   logic          w_done_next;
   logic          r_err;
   logic          w_err_next;

   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;

   assign w_full   = (r_count == CW'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   // A full FIFO refuses every triplet, even if the PE drains the head this same cycle.
   assign w_accept = bus_valid && !w_full && (X_TAG == X_ID);
   assign w_push   = w_accept && !clr;
   assign w_pop    = !w_empty && pe_ready && !clr;

   // Storage has no reset; the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_ifmap[r_wr_ptr] <= ifmap_data_G2B;
         r_mem_fltr[r_wr_ptr]  <= fltr_data_G2B;
         r_mem_psum[r_wr_ptr]  <= psum_data_G2B;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Window FSM; accepts seen while idle (including the start cycle) are flagged as excess.
   always_comb begin
      w_state_next     = r_state;
      w_remaining_next = r_remaining;
      w_done_next      = 1'b0;
      w_err_next       = r_err;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_err_next = 1'b1;
            end
            if (start) begin
               if (kernel_size != 8'd0) begin
                  w_state_next     = S_BUSY;
                  w_remaining_next = kernel_size;
               end else begin
                  w_done_next = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (w_accept) begin
               if (r_remaining == 8'd1) begin
                  w_state_next     = S_IDLE;
                  w_remaining_next = 8'd0;
                  w_done_next      = 1'b1;
               end else begin
                  w_remaining_next = r_remaining - 8'd1;
               end
            end
         end
         default: begin
            w_state_next     = S_IDLE;
            w_remaining_next = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_remaining <= 8'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else if (clr) begin
         r_state     <= S_IDLE;
         r_remaining <= 8'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_remaining <= w_remaining_next;
         r_done      <= w_done_next;
         r_err       <= w_err_next;
      end
   end

   assign bus_ready   = !w_full;
   assign pe_valid    = !w_empty;
   assign pe_ifmap    = w_empty ? '0 : r_mem_ifmap[r_rd_ptr];
   assign pe_fltr     = w_empty ? '0 : r_mem_fltr[r_rd_ptr];
   assign pe_psum     = w_empty ? '0 : r_mem_psum[r_rd_ptr];
   assign fill_level  = r_count;
   assign window_busy = (r_state == S_BUSY);
   assign window_done = r_done;
   assign err_excess  = r_err;

endmodule

// File: tb/tb_xbus_pe_receiver.sv
// Table-driven bench for xbus_pe_receiver: per-cycle vectors with expected control outputs,
// plus a triplet scoreboard checking FIFO head data and order.
module tb_xbus_pe_receiver;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int FD = 4;
   localparam int TW = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          clr = 1'b0;
   logic [TW-1:0] X_ID = '0;
   logic          bus_valid = 1'b0;
   logic          bus_ready;
   logic [TW-1:0] X_TAG = '0;
   logic [DW-1:0] ifmap_data_G2B = '0;
   logic [DW-1:0] fltr_data_G2B = '0;
   logic [2*DW-1:0] psum_data_G2B = '0;
   logic          start = 1'b0;
   logic [7:0]    kernel_size = '0;
   logic          pe_valid;
   logic          pe_ready = 1'b0;
   logic [DW-1:0] pe_ifmap;
   logic [DW-1:0] pe_fltr;
   logic [2*DW-1:0] pe_psum;
   logic [2:0]    fill_level;
   logic          window_busy;
   logic          window_done;
   logic          err_excess;

   xbus_pe_receiver #(
      .DATA_WIDTH (DW),
      .NUM_COL    (NC),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .clr            (clr),
      .X_ID           (X_ID),
      .bus_valid      (bus_valid),
      .bus_ready      (bus_ready),
      .X_TAG          (X_TAG),
      .ifmap_data_G2B (ifmap_data_G2B),
      .fltr_data_G2B  (fltr_data_G2B),
      .psum_data_G2B  (psum_data_G2B),
      .start          (start),
      .kernel_size    (kernel_size),
      .pe_valid       (pe_valid),
      .pe_ready       (pe_ready),
      .pe_ifmap       (pe_ifmap),
      .pe_fltr        (pe_fltr),
      .pe_psum        (pe_psum),
      .fill_level     (fill_level),
      .window_busy    (window_busy),
      .window_done    (window_done),
      .err_excess     (err_excess)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] xid;
      logic          bv;
      logic [TW-1:0] tag;
      logic [15:0]   ifm;
      logic          st;
      logic [7:0]    ks;
      logic          rdy;
      logic          cl;
      logic [2:0]    e_fill;
      logic          e_brdy;
      logic          e_pv;
      logic          e_busy;
      logic          e_done;
      logic          e_err;
   } vec_t;

   typedef struct {
      logic [DW-1:0]   i;
      logic [DW-1:0]   f;
      logic [2*DW-1:0] p;
   } trip_t;

   vec_t  tbl[$];
   trip_t sb[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   function automatic logic [DW-1:0] fltr_of(input logic [DW-1:0] ifm);
      return ifm ^ 16'hA5A5;
   endfunction

   function automatic logic [2*DW-1:0] psum_of(input logic [DW-1:0] ifm);
      return {~ifm, ifm + 16'h1000};
   endfunction

   task automatic add(input int xid, input int bv, input int tag, input int ifm, input int st,
                      input int ks, input int rdy, input int cl, input int e_fill, input int e_brdy,
                      input int e_pv, input int e_busy, input int e_done, input int e_err);
      vec_t v;
      v.xid = TW'(xid);   v.bv = 1'(bv);     v.tag = TW'(tag);     v.ifm = 16'(ifm);
      v.st = 1'(st);      v.ks = 8'(ks);     v.rdy = 1'(rdy);      v.cl = 1'(cl);
      v.e_fill = 3'(e_fill); v.e_brdy = 1'(e_brdy); v.e_pv = 1'(e_pv);
      v.e_busy = 1'(e_busy); v.e_done = 1'(e_done); v.e_err = 1'(e_err);
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " fill_level"}, 32'(fill_level), 32'd0);
      chk({tag, " pe_valid"}, 32'(pe_valid), 32'd0);
      chk({tag, " pe_ifmap"}, 32'(pe_ifmap), 32'd0);
      chk({tag, " pe_psum"}, pe_psum, 32'd0);
      chk({tag, " window_busy"}, 32'(window_busy), 32'd0);
      chk({tag, " window_done"}, 32'(window_done), 32'd0);
      chk({tag, " err_excess"}, 32'(err_excess), 32'd0);
   endtask

   // Drive one vector, check head data against the scoreboard, step one clock, check control.
   task automatic apply(input vec_t v, input int idx);
      int    n;
      trip_t t;
      string nm;
      X_ID           = v.xid;
      bus_valid      = v.bv;
      X_TAG          = v.tag;
      ifmap_data_G2B = v.ifm;
      fltr_data_G2B  = fltr_of(v.ifm);
      psum_data_G2B  = psum_of(v.ifm);
      start          = v.st;
      kernel_size    = v.ks;
      pe_ready       = v.rdy;
      clr            = v.cl;
      #1;
      nm = $sformatf("v%0d", idx);
      n = sb.size();
      if (v.cl) begin
         sb.delete();
      end else begin
         if (n > 0) begin
            chk({nm, " pe_valid(head)"}, 32'(pe_valid), 32'd1);
            chk({nm, " pe_ifmap"}, 32'(pe_ifmap), 32'(sb[0].i));
            chk({nm, " pe_fltr"}, 32'(pe_fltr), 32'(sb[0].f));
            chk({nm, " pe_psum"}, pe_psum, sb[0].p);
            if (v.rdy) begin
               void'(sb.pop_front());
            end
         end
         if (v.bv && (v.tag == v.xid) && (n < FD)) begin
            t.i = v.ifm;
            t.f = fltr_of(v.ifm);
            t.p = psum_of(v.ifm);
            sb.push_back(t);
         end
      end
      @(posedge clk);
      #1;
      chk({nm, " fill_level"}, 32'(fill_level), 32'(v.e_fill));
      chk({nm, " bus_ready"}, 32'(bus_ready), 32'(v.e_brdy));
      chk({nm, " pe_valid"}, 32'(pe_valid), 32'(v.e_pv));
      chk({nm, " window_busy"}, 32'(window_busy), 32'(v.e_busy));
      chk({nm, " window_done"}, 32'(window_done), 32'(v.e_done));
      chk({nm, " err_excess"}, 32'(err_excess), 32'(v.e_err));
      $display("%s: bv=%0d tag=%0d ifm=%h st=%0d ks=%0d rdy=%0d clr=%0d -> fill=%0d brdy=%0d pv=%0d busy=%0d done=%0d err=%0d",
               nm, v.bv, v.tag, v.ifm, v.st, v.ks, v.rdy, v.cl, fill_level, bus_ready, pe_valid,
               window_busy, window_done, err_excess);
   endtask

   initial begin
      //   xid bv tag ifm     st ks rdy cl | fill brdy pv busy done err
      // In-order delivery of a 3-triplet window with the PE always ready
      add(2, 0, 0, 'h0000, 1, 3, 1, 0,  0, 1, 0, 1, 0, 0);
      add(2, 1, 2, 'h0011, 0, 0, 1, 0,  1, 1, 1, 1, 0, 0);
      add(2, 1, 2, 'h0022, 0, 0, 1, 0,  1, 1, 1, 1, 0, 0);
      add(2, 1, 2, 'h0033, 0, 0, 1, 0,  1, 1, 1, 0, 1, 0);
      add(2, 0, 0, 'h0000, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
      // Tag filtering, X_ID=1
      add(1, 0, 0, 'h0000, 1, 2, 0, 0,  0, 1, 0, 1, 0, 0);
      add(1, 1, 0, 'h0100, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
      add(1, 1, 1, 'h0101, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 2, 'h0102, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 3, 'h0103, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 0, 'h0104, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0105, 0, 0, 0, 0,  2, 1, 1, 0, 1, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
      // Fill to full, back-pressure, pop-only while full, then drain
      add(1, 0, 0, 'h0000, 1, 5, 0, 0,  0, 1, 0, 1, 0, 0);
      add(1, 1, 1, 'h0201, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0202, 0, 0, 0, 0,  2, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0203, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0204, 0, 0, 0, 0,  4, 0, 1, 1, 0, 0);
      add(1, 1, 0, 'h0299, 0, 0, 0, 0,  4, 0, 1, 1, 0, 0);
      add(1, 1, 1, 'h0205, 0, 0, 0, 0,  4, 0, 1, 1, 0, 0);
      add(1, 1, 1, 'h0205, 0, 0, 1, 0,  3, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0205, 0, 0, 0, 0,  4, 0, 1, 0, 1, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  3, 1, 1, 0, 0, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
      // Excess accepts while idle, sticky flag, clr; accept in the start cycle
      add(1, 1, 1, 'h0301, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1);
      add(1, 0, 0, 'h0000, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1);
      add(1, 1, 1, 'h0302, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0);
      add(1, 1, 1, 'h0303, 1, 1, 0, 0,  1, 1, 1, 1, 0, 1);
      add(1, 1, 1, 'h0304, 0, 0, 0, 0,  2, 1, 1, 0, 1, 1);
      add(1, 0, 0, 'h0000, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
      // kernel_size=0, and start while busy is ignored
      add(1, 0, 0, 'h0000, 1, 0, 0, 0,  0, 1, 0, 0, 1, 0);
      add(1, 0, 0, 'h0000, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 'h0000, 1, 2, 0, 0,  0, 1, 0, 1, 0, 0);
      add(1, 1, 1, 'h0401, 1, 5, 1, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0402, 0, 0, 1, 0,  1, 1, 1, 0, 1, 0);
      add(1, 0, 0, 'h0000, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
      // Open a 4-triplet window and receive 2 before the async reset below
      add(1, 0, 0, 'h0000, 1, 4, 0, 0,  0, 1, 0, 1, 0, 0);
      add(1, 1, 1, 'h0501, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
      add(1, 1, 1, 'h0502, 0, 0, 0, 0,  2, 1, 1, 1, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("in_reset");
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk_idle_outputs("after_reset");
      chk("after_reset bus_ready", 32'(bus_ready), 32'd1);
      $display("reset released: fill=%0d brdy=%0d pv=%0d", fill_level, bus_ready, pe_valid);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      // Asynchronous reset in mid-window: outputs clear without waiting for a clock edge
      bus_valid = 1'b0;
      start     = 1'b0;
      pe_ready  = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk_idle_outputs("async_reset");
      sb.delete();
      $display("async reset mid-window: fill=%0d busy=%0d done=%0d", fill_level, window_busy, window_done);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_reset%0d window_done", c), 32'(window_done), 32'd0);
         chk($sformatf("post_reset%0d window_busy", c), 32'(window_busy), 32'd0);
         chk($sformatf("post_reset%0d fill_level", c), 32'(fill_level), 32'd0);
         $display("post-reset cycle %0d: fill=%0d busy=%0d done=%0d", c, fill_level, window_busy, window_done);
      end
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
